// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiplier FSM state encoding and counter width helper.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mul_state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/nbit_adder.sv
// Shared ripple adder used across the ALU; Cout flags signed overflow, not carry-out.
module nbit_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    assign Sum  = A + B + WIDTH'(Cin);
    assign Cout = (A[WIDTH-1] == B[WIDTH-1]) && (Sum[WIDTH-1] != A[WIDTH-1]);

endmodule

// File: rtl/seq_multiplier.sv
// Iterative unsigned shift-and-add multiplier built around one shared nbit_adder.
// Optional early exit on exhausted multiplier bits: SEQ_MULTIPLIER_EARLY_TERM_EN.
//
// state | meaning
// IDLE  | waiting for Start
// RUN   | one partial product per cycle, cnt counts remaining steps
// DONE  | one-cycle result pulse; Start here launches the next multiply
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               Start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               Busy,
    output logic               Done,
    output logic [2*WIDTH-1:0] Product
);
    import alu_pkg::*;

    localparam int CW = cnt_width(WIDTH);

    mul_state_t         state, state_next;
    logic [WIDTH-1:0]   mcand, mcand_next;
    logic [2*WIDTH-1:0] p, p_next;
    logic [CW-1:0]      cnt, cnt_next;
    logic [2*WIDTH-1:0] product, product_next;

    logic [WIDTH:0]     add_a, add_b, sum;
    logic               add_cout_unused;
    logic               run_last;
    logic [2*WIDTH-1:0] run_product;

    // Cout is an overflow flag; the carry comes from the extra Sum bit instead
    assign add_a = {1'b0, p[2*WIDTH-1:WIDTH]};
    assign add_b = p[0] ? {1'b0, mcand} : '0;

    nbit_adder #(
        .WIDTH (WIDTH + 1)
    ) u_adder (
        .A    (add_a),
        .B    (add_b),
        .Cin  (1'b0),
        .Sum  (sum),
        .Cout (add_cout_unused)
    );

`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
    logic [WIDTH-1:0] rem_mask;
    logic             rem_zero;

    // After this step, bits p[cnt-1:1] are the multiplier bits still to consume
    assign rem_mask    = {WIDTH{1'b1}} >> (WIDTH + 1 - int'(cnt));
    assign rem_zero    = (({1'b0, p[WIDTH-1:1]} & rem_mask) == '0);
    assign run_last    = rem_zero;
    assign run_product = {sum, p[WIDTH-1:1]} >> (cnt - CW'(1));
`else
    assign run_last    = (cnt == CW'(1));
    assign run_product = {sum, p[WIDTH-1:1]};
`endif

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state   <= IDLE;
            mcand   <= '0;
            p       <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            state   <= state_next;
            mcand   <= mcand_next;
            p       <= p_next;
            cnt     <= cnt_next;
            product <= product_next;
        end
    end

    always_comb begin
        state_next   = state;
        mcand_next   = mcand;
        p_next       = p;
        cnt_next     = cnt;
        product_next = product;
        case (state)
            IDLE, DONE: begin
                if (Start) begin
                    mcand_next = A;
                    p_next     = {{WIDTH{1'b0}}, B};
                    cnt_next   = CW'(WIDTH);
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                p_next   = {sum, p[WIDTH-1:1]};
                cnt_next = cnt - CW'(1);
                if (run_last) begin
                    product_next = run_product;
                    state_next   = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign Busy    = (state == RUN);
    assign Done    = (state == DONE);
    assign Product = product;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier at WIDTH=8 using a product scoreboard.
module tb_seq_multiplier;
    localparam int W = 8;

    logic           Clk = 1'b0;
    logic           Rst_n = 1'b0;
    logic           Start = 1'b0;
    logic [W-1:0]   A = '0;
    logic [W-1:0]   B = '0;
    logic           Busy;
    logic           Done;
    logic [2*W-1:0] Product;

    int n_tests = 0;
    int n_fail  = 0;
    logic [2*W-1:0] sb[$];

    always #5 Clk = ~Clk;

    seq_multiplier #(.WIDTH(W)) dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .Start   (Start),
        .A       (A),
        .B       (B),
        .Busy    (Busy),
        .Done    (Done),
        .Product (Product)
    );

    // Edges counted from the one that samples Start up to the one that raises Done
    function automatic int exp_lat(input logic [W-1:0] b);
`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
        int msb = -1;
        for (int i = 0; i < W; i++) if (b[i]) msb = i;
        return (msb < 0) ? 2 : msb + 2;
`else
        return W + 1;
`endif
    endfunction

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] e;
        e = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        sb.push_back(e);
        A = a;
        B = b;
        Start = 1'b1;
    endtask

    task automatic wait_done(output int edges, output int busy_cnt, output bit held,
                             output bit first_busy, output bit timed_out);
        logic [2*W-1:0] prev;
        prev = Product;
        edges = 0; busy_cnt = 0; held = 1'b1; first_busy = 1'b0; timed_out = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge Clk);
            #1;
            edges++;
            Start = 1'b0;
            A = W'($urandom);
            B = W'($urandom);
            if (i == 0) first_busy = Busy;
            if (Busy) busy_cnt++;
            if (Done) begin
                timed_out = 1'b0;
                break;
            end
            if (Product !== prev) held = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge Clk);
        #1;
        n_tests++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Product !== '0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b product=%0d, required 0 0 0", Busy, Done, Product);
        end
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_basic();
        logic [W-1:0] ta[6] = '{8'd13, 8'd255, 8'd0, 8'd200, 8'd1, 8'd170};
        logic [W-1:0] tb[6] = '{8'd11, 8'd255, 8'd200, 8'd0, 8'd1, 8'd85};
        int edges, busy_cnt;
        bit held, fb, to;
        logic [2*W-1:0] e;
        for (int k = 0; k < 6; k++) begin
            start_op(ta[k], tb[k]);
            wait_done(edges, busy_cnt, held, fb, to);
            e = sb.pop_front();
            n_tests++;
            if (to) begin
                n_fail++;
                $display("FAIL basic_timeout[%0d]: no Done within 40 edges", k);
                continue;
            end
            if (edges != exp_lat(tb[k])) begin
                n_fail++;
                $display("FAIL basic_latency[%0d]: got %0d edges, required %0d", k, edges, exp_lat(tb[k]));
            end
            n_tests++;
            if (Product !== e) begin
                n_fail++;
                $display("FAIL basic_product[%0d]: got %0d, required %0d", k, Product, e);
            end
            n_tests++;
            if (!held) begin
                n_fail++;
                $display("FAIL basic_hold[%0d]: Product changed during RUN (held=%0b, required 1)", k, held);
            end
            n_tests++;
            if (busy_cnt != exp_lat(tb[k]) - 1) begin
                n_fail++;
                $display("FAIL basic_busy[%0d]: busy %0d cycles, required %0d", k, busy_cnt, exp_lat(tb[k]) - 1);
            end
            @(posedge Clk);
            #1;
            n_tests++;
            if (Done !== 1'b0 || Busy !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_pulse[%0d]: done=%b busy=%b after pulse, required 0 0", k, Done, Busy);
            end
        end
    endtask

    task automatic test_early_term();
        logic [W-1:0] ta[3] = '{8'd77, 8'd3, 8'd5};
        logic [W-1:0] tb[3] = '{8'd1, 8'h10, 8'h80};
        int edges, busy_cnt;
        bit held, fb, to;
        logic [2*W-1:0] e;
        for (int k = 0; k < 3; k++) begin
            start_op(ta[k], tb[k]);
            wait_done(edges, busy_cnt, held, fb, to);
            e = sb.pop_front();
            n_tests++;
            if (to || edges != exp_lat(tb[k])) begin
                n_fail++;
                $display("FAIL early_latency[%0d]: got %0d edges (timeout=%0b), required %0d", k, edges, to, exp_lat(tb[k]));
            end
            n_tests++;
            if (Product !== e) begin
                n_fail++;
                $display("FAIL early_product[%0d]: got %0d, required %0d", k, Product, e);
            end
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        int edges, busy_cnt;
        bit held, fb, to;
        logic [2*W-1:0] e;
        start_op(8'd7, 8'd9);
        wait_done(edges, busy_cnt, held, fb, to);
        e = sb.pop_front();
        n_tests++;
        if (to || Product !== e) begin
            n_fail++;
            $display("FAIL b2b_first: got %0d (timeout=%0b), required %0d", Product, to, e);
        end
        start_op(8'd3, 8'd5);
        wait_done(edges, busy_cnt, held, fb, to);
        n_tests++;
        if (fb !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_no_bubble: busy after relaunch edge %b, required 1", fb);
        end
        e = sb.pop_front();
        n_tests++;
        if (to || edges != exp_lat(8'd5)) begin
            n_fail++;
            $display("FAIL b2b_latency: got %0d edges (timeout=%0b), required %0d", edges, to, exp_lat(8'd5));
        end
        n_tests++;
        if (Product !== e) begin
            n_fail++;
            $display("FAIL b2b_second: got %0d, required %0d", Product, e);
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic test_ignore_start();
        int edges;
        bit to;
        logic [2*W-1:0] e;
        start_op(8'd6, 8'd6);
        edges = 0;
        to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge Clk);
            #1;
            edges++;
            Start = 1'b0;
            if (i == 2) begin
                Start = 1'b1;
                A = 8'd1;
                B = 8'd1;
            end
            if (Done) begin
                to = 1'b0;
                break;
            end
        end
        Start = 1'b0;
        e = sb.pop_front();
        n_tests++;
        if (to || edges != exp_lat(8'd6)) begin
            n_fail++;
            $display("FAIL ignore_latency: got %0d edges (timeout=%0b), required %0d", edges, to, exp_lat(8'd6));
        end
        n_tests++;
        if (Product !== e) begin
            n_fail++;
            $display("FAIL ignore_product: got %0d, required %0d", Product, e);
        end
        repeat (2) @(posedge Clk);
        #1;
        n_tests++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_no_queue: busy=%b done=%b, required 0 0", Busy, Done);
        end
    endtask

    task automatic test_reset_mid_run();
        int edges, busy_cnt;
        bit held, fb, to;
        logic [2*W-1:0] e;
        start_op(8'd200, 8'd201);
        repeat (4) @(posedge Clk);
        #1;
        Start = 1'b0;
        void'(sb.pop_back());
        Rst_n = 1'b0;
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        n_tests++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Product !== '0) begin
            n_fail++;
            $display("FAIL midrun_reset: busy=%b done=%b product=%0d, required 0 0 0", Busy, Done, Product);
        end
        repeat (3) @(posedge Clk);
        #1;
        n_tests++;
        if (Done !== 1'b0 || Product !== '0) begin
            n_fail++;
            $display("FAIL midrun_discard: done=%b product=%0d, required 0 0", Done, Product);
        end
        start_op(8'd9, 8'd9);
        wait_done(edges, busy_cnt, held, fb, to);
        e = sb.pop_front();
        n_tests++;
        if (to || edges != exp_lat(8'd9) || Product !== e) begin
            n_fail++;
            $display("FAIL midrun_restart: product=%0d edges=%0d timeout=%0b, required %0d in %0d",
                     Product, edges, to, e, exp_lat(8'd9));
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic test_random();
        int edges, busy_cnt;
        bit held, fb, to;
        logic [W-1:0] a, b;
        logic [2*W-1:0] e;
        for (int k = 0; k < 20; k++) begin
            a = W'($urandom);
            b = W'($urandom);
            start_op(a, b);
            wait_done(edges, busy_cnt, held, fb, to);
            e = sb.pop_front();
            n_tests++;
            if (to || edges != exp_lat(b) || Product !== e) begin
                n_fail++;
                $display("FAIL random[%0d]: %0d*%0d got %0d in %0d edges (timeout=%0b), required %0d in %0d",
                         k, a, b, Product, edges, to, e, exp_lat(b));
            end
            if (k % 3 == 0) begin
                @(posedge Clk);
                #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_early_term();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
